// File: rtl/sev_seg_scan_ctrl.sv
// Eight-digit seven-segment scanner: BLANK gap then SHOW slot per digit, round-robin, all outputs registered.
// Register port has one-cycle read latency, no backpressure; writes and reads accepted every cycle.
module sev_seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [7:0]  sev_seg_an,
  output logic [6:0]  sev_seg_ca
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  logic [31:0]   r_data;
  logic [7:0]    r_mask;
  logic          r_en;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [3:0]    r_sh_nib;
  logic          r_sh_msk;

  logic [3:0]    w_nib;
  logic          w_msk;
  logic [7:0]    w_an_sel;
  logic [31:0]   w_status;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_nib    = r_data[{r_idx, 2'b00} +: 4];
  assign w_msk    = r_mask[r_idx];
  assign w_an_sel = ~(8'd1 << r_idx);
  assign w_status = {28'd0, (r_state == S_SHOW), r_idx};

  // Register port; nonblocking update makes a same-cycle read return the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= 32'd0;
      r_mask  <= 8'd0;
      r_en    <= 1'b0;
      o_rdata <= 32'd0;
    end else begin
      if (i_we) begin
        case (i_addr)
          2'd0:    r_data <= i_wdata;
          2'd1:    r_mask <= i_wdata[7:0];
          2'd2:    r_en   <= i_wdata[0];
          default: ;
        endcase
      end
      if (i_re) begin
        case (i_addr)
          2'd0:    o_rdata <= r_data;
          2'd1:    o_rdata <= {24'd0, r_mask};
          2'd2:    o_rdata <= {31'd0, r_en};
          default: o_rdata <= w_status;
        endcase
      end
    end
  end

  // Anode/cathode registers are loaded on the same edge as the state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_sh_nib   <= 4'd0;
      r_sh_msk   <= 1'b0;
      sev_seg_an <= 8'hFF;
      sev_seg_ca <= 7'h7F;
    end else if (!r_en) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      sev_seg_an <= 8'hFF;
      sev_seg_ca <= 7'h7F;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_BLANK;
          r_cnt      <= '0;
          sev_seg_an <= 8'hFF;
          sev_seg_ca <= 7'h7F;
        end
        S_BLANK: begin
          if (r_cnt == BLK_LAST) begin
            r_state    <= S_SHOW;
            r_cnt      <= '0;
            r_sh_nib   <= w_nib;
            r_sh_msk   <= w_msk;
            sev_seg_an <= w_msk ? 8'hFF : w_an_sel;
            sev_seg_ca <= hex7(w_nib);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SHOW: begin
          if (r_cnt == DIG_LAST) begin
            r_state    <= S_BLANK;
            r_cnt      <= '0;
            r_idx      <= r_idx + 3'd1;
            sev_seg_an <= 8'hFF;
            sev_seg_ca <= 7'h7F;
          end else begin
            r_cnt      <= r_cnt + CW'(1);
            sev_seg_an <= r_sh_msk ? 8'hFF : w_an_sel;
            sev_seg_ca <= hex7(r_sh_nib);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_idx      <= 3'd0;
          sev_seg_an <= 8'hFF;
          sev_seg_ca <= 7'h7F;
        end
      endcase
    end
  end

endmodule

// File: doc/sev_seg_scan_ctrl.md
# sev_seg_scan_ctrl

Time-multiplexing controller for the eight-digit seven-segment display on the SoC board. It shares the single cathode bus among eight anodes by scanning the digits in a fixed round-robin order. A blanking gap between digits suppresses ghosting. The CPU configures it through a small register port on the SoC peripheral bus, and it drives `sev_seg_an` / `sev_seg_ca` at the SoC top level.

## Interface
Parameters:
- `DIGIT_CYCLES`, default 100000: clock cycles each digit is lit (SHOW phase). Must be ≥ 2.
- `BLANK_CYCLES`, default 1000: clock cycles with all anodes off before each digit. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `i_we`  in  1  register write strobe, single cycle.
- `i_re`  in  1  register read strobe, single cycle.
- `i_addr`  in  2  register word select.
- `i_wdata`  in  32  write data.
- `o_rdata`  out  32  read data, registered.
- `sev_seg_an`  out  8  anodes, active-low. Bit n selects digit n.
- `sev_seg_ca`  out  7  cathodes, active-low. Bit order is {g,f,e,d,c,b,a}.

## Operation
Registers:
- addr 0 DATA: eight hex nibbles, R/W. Nibble n (bits 4n+3:4n) is the value for digit n.
- addr 1 MASK: bits 7:0, R/W. A set bit blanks that digit. Upper bits read 0.
- addr 2 CTRL: bit 0 is EN, R/W. Upper bits read 0.
- addr 3 STATUS: read-only. Bits 2:0 hold the current digit index; bit 3 is 1 during SHOW. Writes to STATUS are ignored.

FSM states:
- IDLE
  - Anodes 8'hFF, cathodes 7'h7F.
  - Digit index is held at 0.
  - When EN=1, go to BLANK.
- BLANK
  - Anodes 8'hFF, cathodes 7'h7F.
  - Lasts BLANK_CYCLES cycles, then go to SHOW.
  - On entry to SHOW, latch DATA nibble[idx] and MASK[idx] into a shadow register.
- SHOW
  - Anode bit idx is driven 0, unless the shadowed mask bit is set; in that case all anodes stay 1.
  - Cathodes show the hex decode of the shadowed nibble.
  - Lasts DIGIT_CYCLES cycles. Then idx = idx+1 mod 8 (7 wraps to 0) and the FSM goes to BLANK.
- From any state, EN=0 sends the FSM to IDLE on the next clock and resets idx to 0.

Hex decode (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

A blanked digit still uses its full SHOW time slot, so the scan period stays constant at 8×(DIGIT_CYCLES+BLANK_CYCLES).

## Timing
- Reset values:
  - FSM is IDLE, idx=0, phase counter=0.
  - DATA=0, MASK=0, EN=0.
  - `sev_seg_an`=8'hFF, `sev_seg_ca`=7'h7F, `o_rdata`=0.
- All outputs are registered. The anode and cathode outputs change on the same clock edge as the FSM state, so there is never a cycle where a lit anode carries stale cathodes.
- Write with EN 0→1 at edge T: the FSM is in BLANK from T+1, and digit 0 is lit from T+1+BLANK_CYCLES.
- Write with EN 1→0 at edge T: anodes are 8'hFF from T+1.
- DATA or MASK writes during SHOW do not change the lit digit. They take effect at that digit's next SHOW entry.
- Write and SHOW entry on the same edge: the shadow captures the old value.
- Read: `o_rdata` is valid on the cycle after `i_re`, and holds until the next `i_re`. A read concurrent with a write to the same address returns the old value.
- `i_we` and `i_re` may be asserted together. Both take effect.
- Reset asserted mid-scan returns every output to its reset value on the next edge.

## Test plan
Run with DIGIT_CYCLES=4 and BLANK_CYCLES=2.
- **Reset and idle:** apply reset, then leave EN=0 for 50 cycles. Expect an=FF, ca=7F and rdata=0 throughout.
- **Full scan:** write DATA=0x76543210, then EN=1 at edge T. Expect:
  - Digit 0 (an=FE, ca=1000000) during T+3..T+6.
  - Digit 1 (an=FD, ca=1111001) six cycles later.
  - Wrap to digit 0 after 48 cycles.
- **Mask:** write MASK=0x05 and DATA=0xFEDCBA98. Expect an to stay FF during the slots for digits 0 and 2. Digit 1 shows ca=0010000 (9).
- **Mid-SHOW write:** while digit 3 is lit, write DATA nibble 3 = A. Expect the current slot unchanged; the next visit to digit 3 shows ca=0001000.
- **Disable and reset mid-scan:** clear EN during digit 5 SHOW. Expect an=FF next cycle, with STATUS reading 0 afterwards. Re-enable, then assert reset mid-BLANK. Expect all reset values, including EN read back as 0.
- **Register readback:** write 0xFFFFFFFF to MASK, CTRL and STATUS. Expect:
  - MASK reads 0x000000FF one cycle after `i_re`.
  - CTRL reads 0x00000001.
  - STATUS is unaffected by the write.
